// File: rtl/vec_activation_if.sv
// Chunk handshake shared by vec_activation and its neighbouring VecFIFOs.
// Carries the mode select, the upstream chunk read path, the downstream
// chunk write path and the end-of-vector flag.
interface vec_activation_if #(
  parameter int WorkingRegs = 4,
  parameter int ElemWidth   = 8
);
  logic [1:0]                       mode;
  logic                             in_data_ready;
  logic [WorkingRegs*ElemWidth-1:0] in_data;
  logic                             req_chunk_in;
  logic [WorkingRegs*ElemWidth-1:0] write_out_data;
  logic                             req_chunk_out;
  logic                             out_vector_valid;

  // Environment side: mode source, upstream FIFO and downstream FIFO.
  modport master (
    output mode, in_data_ready, in_data,
    input  req_chunk_in, write_out_data, req_chunk_out, out_vector_valid
  );

  // Activation stage side.
  modport slave (
    input  mode, in_data_ready, in_data,
    output req_chunk_in, write_out_data, req_chunk_out, out_vector_valid
  );
endinterface

// File: rtl/vec_activation.sv
// Elementwise activation stage for the vector pipeline.
// Reads InVecLength/WorkingRegs chunks from the upstream FIFO, applies the
// activation selected by mode (pass, ReLU, leaky ReLU, clamp) and writes
// each result chunk downstream two cycles after its read strobe.
// Optional build macro VEC_ACTIVATION_LEAK_ROUND_EN: leaky ReLU rounds to
// nearest instead of flooring.
module vec_activation #(
  parameter int InVecLength = 4,
  parameter int WorkingRegs = 4,
  parameter int ElemWidth   = 8,
  parameter int LeakShift   = 3,
  parameter int ClampMax    = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  vec_activation_if.slave  bus
);

  localparam int NumChunks  = InVecLength / WorkingRegs;
  localparam int CntWidth   = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int ChunkWidth = WorkingRegs * ElemWidth;

  localparam logic [CntWidth-1:0]         LastChunk = CntWidth'(NumChunks - 1);
  localparam logic signed [ElemWidth-1:0] ClampMaxV = ElemWidth'(ClampMax);
`ifdef VEC_ACTIVATION_LEAK_ROUND_EN
  localparam logic signed [ElemWidth:0]   RoundBias = (ElemWidth + 1)'(1 << (LeakShift - 1));
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLAMP = 2'd3
  } mode_e;

  state_e                 state_q;
  state_e                 state_d;
  logic                   start;
  logic                   last_write;
  mode_e                  mode_q;
  logic [CntWidth-1:0]    req_cnt_q;
  logic [CntWidth-1:0]    out_cnt_q;
  logic                   in_valid_q;
  logic                   out_strobe_q;
  logic [ChunkWidth-1:0]  out_data_q;
  logic [ChunkWidth-1:0]  act_chunk;
  logic                   vec_valid_q;

  // Single-element activation; every result fits back into ElemWidth bits.
  function automatic logic signed [ElemWidth-1:0] activate(
    input logic signed [ElemWidth-1:0] x,
    input mode_e                       m
  );
    logic signed [ElemWidth-1:0] y;
`ifdef VEC_ACTIVATION_LEAK_ROUND_EN
    logic signed [ElemWidth:0]   sum;
`endif
    y = x;
    case (m)
      MODE_PASS: y = x;
      MODE_RELU: y = x[ElemWidth-1] ? '0 : x;
      MODE_LEAKY: begin
        if (x[ElemWidth-1]) begin
`ifdef VEC_ACTIVATION_LEAK_ROUND_EN
          // One extra bit so adding the half-LSB bias can never wrap.
          sum = {x[ElemWidth-1], x} + RoundBias;
          y   = ElemWidth'(sum >>> LeakShift);
`else
          y = x >>> LeakShift;
`endif
        end
      end
      MODE_CLAMP: begin
        if (x[ElemWidth-1]) begin
          y = '0;
        end else if (x > ClampMaxV) begin
          y = ClampMaxV;
        end else begin
          y = x;
        end
      end
      default: y = x;
    endcase
    return y;
  endfunction

  // The final chunk of the vector is registered on this edge.
  assign last_write = in_valid_q && (out_cnt_q == LastChunk);

  // State register.
  always_ff @(posedge clk_in) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and vector start detection.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_data_ready) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (req_cnt_q == LastChunk) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_write) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Requiring ready low here forces a low-then-high before a new vector.
        if (!bus.in_data_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode latch and read-request chunk counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q    <= MODE_PASS;
      req_cnt_q <= '0;
    end else if (start) begin
      mode_q    <= mode_e'(bus.mode);
      req_cnt_q <= '0;
    end else if (state_q == RUN && req_cnt_q != LastChunk) begin
      req_cnt_q <= req_cnt_q + CntWidth'(1);
    end
  end

  // Apply the latched activation to every element of the incoming chunk.
  always_comb begin
    act_chunk = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      act_chunk[i*ElemWidth +: ElemWidth] =
        activate(bus.in_data[i*ElemWidth +: ElemWidth], mode_q);
    end
  end

  // Two-stage pipeline: read strobe -> data valid -> registered result.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_valid_q   <= 1'b0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
    end else begin
      in_valid_q   <= (state_q == RUN);
      out_strobe_q <= in_valid_q;
      if (start) begin
        out_cnt_q <= '0;
      end else if (in_valid_q && out_cnt_q != LastChunk) begin
        out_cnt_q <= out_cnt_q + CntWidth'(1);
      end
      if (in_valid_q) begin
        out_data_q <= act_chunk;
      end
    end
  end

  // Vector-complete flag: rises with the final write, held until next start.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vec_valid_q <= 1'b0;
    end else if (start) begin
      vec_valid_q <= 1'b0;
    end else if (last_write) begin
      vec_valid_q <= 1'b1;
    end
  end

  assign bus.req_chunk_in     = (state_q == RUN);
  assign bus.req_chunk_out    = out_strobe_q;
  assign bus.write_out_data   = out_data_q;
  assign bus.out_vector_valid = vec_valid_q;

endmodule

// File: tb/tb_vec_activation.sv
// Self-checking bench for vec_activation.
// dut_a: one 4-element chunk per vector, LeakShift 2.
// dut_b: three 2-element chunks per vector, LeakShift 3.
// Both use ClampMax 6 and share clock and reset.
module tb_vec_activation;

  localparam int EW    = 8;
  localparam int A_IVL = 4;
  localparam int A_WR  = 4;
  localparam int A_LS  = 2;
  localparam int B_IVL = 6;
  localparam int B_WR  = 2;
  localparam int B_LS  = 3;
  localparam int CM    = 6;
  localparam int B_NCH = B_IVL / B_WR;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int a_rd_cnt = 0;

  logic [31:0] a_src[$];
  logic [31:0] a_out[$];
  logic        a_ovv_at_out[$];
  logic [1:0]  a_start_flags;
  logic [15:0] b_src[$];
  logic [15:0] b_out[$];
  logic        b_ovv_at_out[$];
  int          b_rin_t[$];
  int          b_rout_t[$];

  vec_activation_if #(.WorkingRegs(A_WR), .ElemWidth(EW)) a_if ();
  vec_activation_if #(.WorkingRegs(B_WR), .ElemWidth(EW)) b_if ();

  vec_activation #(
    .InVecLength(A_IVL), .WorkingRegs(A_WR), .ElemWidth(EW),
    .LeakShift(A_LS), .ClampMax(CM)
  ) dut_a (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (a_if)
  );

  vec_activation #(
    .InVecLength(B_IVL), .WorkingRegs(B_WR), .ElemWidth(EW),
    .LeakShift(B_LS), .ClampMax(CM)
  ) dut_b (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (b_if)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  // Upstream FIFO for dut_a: a read strobe seen this cycle yields data next cycle.
  always begin : fifo_a
    logic [31:0] c;
    @(negedge clk_in);
    if (a_if.req_chunk_in === 1'b1) begin
      c = (a_src.size() > 0) ? a_src.pop_front() : 32'h0;
      a_rd_cnt++;
      @(posedge clk_in);
      #1 a_if.in_data = c;
    end
  end

  // Upstream FIFO for dut_b.
  always begin : fifo_b
    logic [15:0] c;
    @(negedge clk_in);
    if (b_if.req_chunk_in === 1'b1) begin
      c = (b_src.size() > 0) ? b_src.pop_front() : 16'h0;
      @(posedge clk_in);
      #1 b_if.in_data = c;
    end
  end

  // Downstream FIFOs and strobe timestamps.
  always @(negedge clk_in) begin
    if (a_if.req_chunk_out === 1'b1) begin
      a_out.push_back(a_if.write_out_data);
      a_ovv_at_out.push_back(a_if.out_vector_valid);
    end
    if (b_if.req_chunk_in === 1'b1) b_rin_t.push_back(cyc);
    if (b_if.req_chunk_out === 1'b1) begin
      b_out.push_back(b_if.write_out_data);
      b_ovv_at_out.push_back(b_if.out_vector_valid);
      b_rout_t.push_back(cyc);
    end
  end

  // Reference model: floor division and the activation rules in plain integers.
  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_act(input int x, input int m, input int ls);
    int d;
    d = 1 << ls;
    if (m == 0) return x;
    if (m == 1) return (x < 0) ? 0 : x;
    if (m == 2) begin
      if (x >= 0) return x;
`ifdef VEC_ACTIVATION_LEAK_ROUND_EN
      return floor_div(x + d / 2, d);
`else
      return floor_div(x, d);
`endif
    end
    if (x < 0) return 0;
    return (x > CM) ? CM : x;
  endfunction

  function automatic logic [31:0] ref_chunk(input logic [31:0] x, input int wr,
                                            input int m, input int ls);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < wr; i++) begin
      int r;
      r = ref_act(int'($signed(x[i*EW +: EW])), m, ls);
      y[i*EW +: EW] = r[EW-1:0];
    end
    return y;
  endfunction

  // Element 0 sits in the least significant byte.
  function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  function automatic logic [15:0] b_out_at(input int i);
    return (i < b_out.size()) ? b_out[i] : 16'hxxxx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One vector through dut_a; mode is disturbed after start to prove it is latched.
  task automatic run_a(input logic [1:0] m, input logic [31:0] x, input bit drop,
                       output logic [31:0] y);
    int n;
    a_src.push_back(x);
    a_out.delete();
    a_ovv_at_out.delete();
    a_if.mode          = m;
    a_if.in_data_ready = 1'b1;
    @(negedge clk_in);
    a_start_flags = {a_if.req_chunk_in, a_if.out_vector_valid};
    a_if.mode     = ~m;
    n = 0;
    while (!(a_if.out_vector_valid === 1'b1 && a_out.size() == 1) && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check("a_timeout", 32'(n >= 20), 0);
    check("a_start_req_ovv", 32'(a_start_flags), 32'(2'b10));
    check("a_ovv_with_out", (a_ovv_at_out.size() > 0) ? 32'(a_ovv_at_out[0]) : 32'hx, 1);
    y = (a_out.size() > 0) ? a_out[0] : 32'hxxxxxxxx;
    if (drop) begin
      a_if.in_data_ready = 1'b0;
      repeat (2) @(negedge clk_in);
    end
  endtask

  // One vector of B_NCH chunks through dut_b.
  task automatic run_b(input logic [1:0] m, input logic [15:0] x [B_NCH]);
    int n;
    for (int i = 0; i < B_NCH; i++) b_src.push_back(x[i]);
    b_out.delete();
    b_ovv_at_out.delete();
    b_rin_t.delete();
    b_rout_t.delete();
    b_if.mode          = m;
    b_if.in_data_ready = 1'b1;
    @(negedge clk_in);
    b_if.mode = ~m;
    n = 0;
    while (!(b_if.out_vector_valid === 1'b1 && b_out.size() == B_NCH) && n < 30) begin
      @(negedge clk_in);
      n++;
    end
    check("b_timeout", 32'(n >= 30), 0);
    b_if.in_data_ready = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t        vt [7];
    logic [31:0] y;
    logic [31:0] xr;
    logic [15:0] bx [B_NCH];
    int          mm;
    int          rd0;

    a_if.mode = 2'd0;  a_if.in_data_ready = 1'b0;  a_if.in_data = '0;
    b_if.mode = 2'd0;  b_if.in_data_ready = 1'b0;  b_if.in_data = '0;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("a_reset_strobes", 32'({a_if.req_chunk_in, a_if.req_chunk_out, a_if.out_vector_valid}), 0);
    check("a_reset_data", a_if.write_out_data, 0);
    check("b_reset_strobes", 32'({b_if.req_chunk_in, b_if.req_chunk_out, b_if.out_vector_valid}), 0);
    check("b_reset_data", 32'(b_if.write_out_data), 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Directed single-chunk vectors (LeakShift 2, ClampMax 6).
    vt[0] = '{2'd1, pack4(-5, -3, -1, 1),      pack4(0, 0, 0, 1)};
`ifdef VEC_ACTIVATION_LEAK_ROUND_EN
    vt[1] = '{2'd2, pack4(-5, -8, 7, -1),      pack4(-1, -2, 7, 0)};
    vt[4] = '{2'd2, pack4(-128, -6, -2, 5),    pack4(-32, -1, 0, 5)};
`else
    vt[1] = '{2'd2, pack4(-5, -8, 7, -1),      pack4(-2, -2, 7, -1)};
    vt[4] = '{2'd2, pack4(-128, -6, -2, 5),    pack4(-32, -2, -1, 5)};
`endif
    vt[2] = '{2'd3, pack4(-128, 3, 6, 127),    pack4(0, 3, 6, 6)};
    vt[3] = '{2'd0, pack4(-128, 127, 0, -1),   pack4(-128, 127, 0, -1)};
    vt[5] = '{2'd1, pack4(127, -128, 0, 64),   pack4(127, 0, 0, 64)};
    vt[6] = '{2'd3, pack4(5, 7, -1, 0),        pack4(5, 6, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      run_a(vt[i].mode, vt[i].x, 1'b1, y);
      check($sformatf("table_%0d", i), y, vt[i].y);
    end

    // Random single-chunk vectors against the model.
    for (int k = 0; k < 20; k++) begin
      xr = $urandom();
      mm = $urandom_range(0, 3);
      run_a(2'(mm), xr, 1'b1, y);
      check($sformatf("rand_a_%0d_m%0d", k, mm), y, ref_chunk(xr, A_WR, mm, A_LS));
    end

    // Ready held high after completion must not start a second vector.
    run_a(2'd1, pack4(10, -10, 20, -20), 1'b0, y);
    check("hold_first", y, pack4(10, 0, 20, 0));
    rd0 = a_rd_cnt;
    repeat (10) @(negedge clk_in);
    check("hold_no_reads", 32'(a_rd_cnt - rd0), 0);
    check("hold_ovv", 32'(a_if.out_vector_valid), 1);
    a_if.in_data_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    check("idle_ovv_kept", 32'(a_if.out_vector_valid), 1);
    run_a(2'd3, pack4(-1, 2, -3, 9), 1'b1, y);
    check("second_vector", y, pack4(0, 2, 0, 6));

    // Multi-chunk pass-through timing on dut_b.
    bx[0] = 16'h807f;
    bx[1] = 16'h01ff;
    bx[2] = 16'h3cc3;
    run_b(2'd0, bx);
    for (int i = 0; i < B_NCH; i++) check($sformatf("b_pass_%0d", i), 32'(b_out_at(i)), 32'(bx[i]));
    check("b_rin_count", 32'(b_rin_t.size()), 3);
    check("b_rin_consec", 32'(b_rin_t.size() == 3 && b_rin_t[2] == b_rin_t[0] + 2), 1);
    check("b_rout_count", 32'(b_rout_t.size()), 3);
    check("b_rout_start", 32'(b_rout_t.size() > 0 && b_rin_t.size() > 0 &&
                              b_rout_t[0] == b_rin_t[0] + 2), 1);
    check("b_rout_consec", 32'(b_rout_t.size() == 3 && b_rout_t[2] == b_rout_t[0] + 2), 1);
    check("b_ovv_pattern", (b_ovv_at_out.size() == 3) ?
          32'({b_ovv_at_out[0], b_ovv_at_out[1], b_ovv_at_out[2]}) : 32'hx, 32'(3'b001));

    // Reset while the second chunk is in flight.
    b_src.delete();
    b_out.delete();
    b_rin_t.delete();
    b_rout_t.delete();
    for (int i = 0; i < B_NCH; i++) b_src.push_back(16'($urandom()));
    b_if.mode          = 2'd0;
    b_if.in_data_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_pre_out", 32'(b_if.req_chunk_out), 1);
    rst_in             = 1'b1;
    b_if.in_data_ready = 1'b0;
    @(negedge clk_in);
    check("rst_strobes", 32'({b_if.req_chunk_in, b_if.req_chunk_out, b_if.out_vector_valid}), 0);
    check("rst_data", 32'(b_if.write_out_data), 0);
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    check("rst_no_more_out", 32'(b_out.size()), 1);
    check("rst_reads", 32'(b_rin_t.size()), 3);
    b_src.delete();

    // Fresh random vectors on dut_b after the reset.
    for (int k = 0; k < 10; k++) begin
      mm = (k < 4) ? k : $urandom_range(0, 3);
      for (int i = 0; i < B_NCH; i++) bx[i] = 16'($urandom());
      run_b(2'(mm), bx);
      for (int i = 0; i < B_NCH; i++) begin
        xr = ref_chunk({16'h0, bx[i]}, B_WR, mm, B_LS);
        check($sformatf("rand_b_%0d_c%0d_m%0d", k, i, mm), 32'(b_out_at(i)), {16'h0, xr[15:0]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vec_activation.md
Name: vec_activation

Overview:
- Parametrised elementwise activation stage for the vector pipeline. It is the successor to the fixed single-function ReLU stage.
- Sits between two VecFIFOs and uses the same chunk handshake:
  - pulls WorkingRegs signed elements per request from the upstream FIFO;
  - applies a runtime-selected activation (pass, ReLU, leaky ReLU, clamped ReLU);
  - writes result chunks to the downstream FIFO;
  - flags out_vector_valid once a full vector has been emitted.

Parameters:
- InVecLength, 4, elements per vector; must be a multiple of WorkingRegs.
- WorkingRegs, 4, elements per input/output chunk.
- ElemWidth, 8, bits per signed element.
- LeakShift, 3, leaky slope is 2^-LeakShift (arithmetic right shift); range 1..ElemWidth-1.
- ClampMax, 6, upper bound for clamp mode; signed, must satisfy 0 < ClampMax <= 2^(ElemWidth-1)-1.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- mode  in  2  0 = pass, 1 = ReLU, 2 = leaky ReLU, 3 = clamp [0, ClampMax]; sampled at vector start.
- in_data_ready  in  1  upstream vector complete; level signal.
- in_data  in  WorkingRegs*ElemWidth  chunk from upstream FIFO; valid the cycle after req_chunk_in.
- req_chunk_in  out  1  read strobe to upstream FIFO.
- write_out_data  out  WorkingRegs*ElemWidth  result chunk.
- req_chunk_out  out  1  write strobe to downstream FIFO; write_out_data is valid in the same cycle.
- out_vector_valid  out  1  full output vector written.

Behaviour:
- NumChunks = InVecLength / WorkingRegs. A chunk counter counts 0..NumChunks-1.
- Reset values: req_chunk_in = 0, req_chunk_out = 0, write_out_data = 0, out_vector_valid = 0. State is IDLE, counters are 0 and the in-flight pipeline is cleared.
- States:
  - IDLE:
    - in_data_ready = 1 → RUN; mode is latched, chunk counter is cleared, out_vector_valid is cleared.
  - RUN:
    - req_chunk_in = 1 for exactly NumChunks consecutive cycles, then deasserts.
    - → DRAIN after the last request.
  - DRAIN:
    - waits until the last chunk has been written.
    - then out_vector_valid = 1 (registered, same cycle as the final req_chunk_out) → DONE.
  - DONE:
    - out_vector_valid holds at 1.
    - in_data_ready = 0 → IDLE; out_vector_valid stays 1 in IDLE until the next vector starts.
    - A new vector starts only after in_data_ready has been seen low and then high again.
- Pipeline:
  - Request at cycle t → in_data valid at t+1 → registered result at t+2 with req_chunk_out = 1.
  - Fixed 2-cycle latency. req_chunk_out pulses once per chunk, NumChunks times back-to-back.
- Arithmetic: per element, signed ElemWidth in, ElemWidth out.
  - pass: y = x.
  - ReLU: y = (x < 0) ? 0 : x.
  - leaky ReLU: y = (x < 0) ? (x >>> LeakShift) : x. The shift is arithmetic (floor); no overflow is possible.
  - clamp: y = min(max(x, 0), ClampMax).
- Mode changes during RUN, DRAIN or DONE are ignored; the latched mode applies to the whole vector.
- in_data_ready dropping mid-RUN: no effect; the current vector completes.
- Reset asserted mid-vector: in-flight chunks are discarded, no further strobes are issued, and all outputs return to reset values on the next edge.
- Back-to-back vectors: minimum gap is one IDLE cycle after in_data_ready falls.

Optional Feature:
- Macro: VEC_ACTIVATION_LEAK_ROUND_EN.
- Defined: leaky mode rounds to nearest, y = (x + 2^(LeakShift-1)) >>> LeakShift for x < 0. The addition is done at ElemWidth+1 bits, so there is no wrap.
- Undefined: floor (plain arithmetic shift).
- All other modes, and all timing, are identical in both builds.

Test Plan:
- Integration chain (bias output [-5 -3 -1 1]): mode=1 (ReLU), WorkingRegs=4 → one req_chunk_out at t+2 carrying [0 0 0 1]; out_vector_valid=1 in the same cycle.
- mode=2, LeakShift=2, input [-5 -8 7 -1]:
  - macro off → [-2 -2 7 -1];
  - macro on → [-1 -2 7 0].
- mode=3, ClampMax=6, input [-128 3 6 127] → [0 3 6 6].
- InVecLength=6, WorkingRegs=2, mode=0:
  - req_chunk_in high for 3 consecutive cycles;
  - req_chunk_out high for 3 consecutive cycles, starting 2 cycles later;
  - data passes through unchanged.
- Hold in_data_ready=1 after DONE → no second set of reads. Drop in_data_ready, then raise it → second vector is processed and out_vector_valid goes low in the start cycle.
- Assert rst_in while the second chunk is in flight:
  - no further req_chunk_out;
  - all outputs are 0 on the next edge;
  - a fresh vector afterwards completes correctly.
